fd_strobe_reg_chk: RTL

- Parametrised successor to the single-bit clear/set D flip-flop.
- WIDTH-bit data register captures d on each rising edge of a sampled strobe, with active-low synchronous set/clear (set overrides clear).
- Built-in synthesizable timing-check monitor, measured in clk cycles: setup, hold, positive width, negative width, period window.
- Used in stimulus/checker benches and as a capture stage in silicon, where specify-block checks do not exist.

---
 rtl/fd_chk_pkg.sv | 23 ++
 rtl/fd_sat_timer.sv | 37 +++
 rtl/fd_strobe_reg_chk.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/fd_chk_pkg.sv
// Shared definitions for the strobe capture register and its timing checker:
// violation bit positions, strobe phase encoding and saturating arithmetic.
package fd_chk_pkg;

  localparam int unsigned VIOL_SETUP  = 0;
  localparam int unsigned VIOL_HOLD   = 1;
  localparam int unsigned VIOL_WPOS   = 2;
  localparam int unsigned VIOL_WNEG   = 3;
  localparam int unsigned VIOL_PERIOD = 4;
  localparam int unsigned VIOL_W      = 5;

  typedef enum logic [1:0] {
    PhIdle = 2'd0,
    PhHigh = 2'd1,
    PhLow  = 2'd2
  } phase_e;

  // Increment that sticks at max_val instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/fd_sat_timer.sv
// Saturating up-counter with synchronous restart (to zero) and count enable.
module fd_sat_timer
  import fd_chk_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = CNT_W'(sat_inc(32'(cnt_q), 32'(CntMax)));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fd_strobe_reg_chk.sv
// WIDTH-bit strobe-captured register with sync set/clear and a cycle-based
// timing monitor (setup, hold, pulse widths, period window).
module fd_strobe_reg_chk
  import fd_chk_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned T_SETUP   = 2,
  parameter int unsigned T_HOLD    = 1,
  parameter int unsigned T_WPOS    = 6,
  parameter int unsigned T_WNEG    = 5,
  parameter int unsigned T_PER_MIN = 10,
  parameter int unsigned T_PER_MAX = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stb,
  input  logic [WIDTH-1:0]  d,
  input  logic              clr_n,
  input  logic              set_n,
  input  logic              clr_status,
  output logic [WIDTH-1:0]  q,
  output logic [VIOL_W-1:0] viol,
  output logic [VIOL_W-1:0] status,
  output logic [CNT_W-1:0]  viol_cnt
);

  localparam logic [CNT_W-1:0] CntMax  = '1;
  localparam logic [CNT_W-1:0] TSetup  = CNT_W'(T_SETUP);
  localparam logic [CNT_W-1:0] THold   = CNT_W'(T_HOLD);
  localparam logic [CNT_W-1:0] TWpos   = CNT_W'(T_WPOS);
  localparam logic [CNT_W-1:0] TWneg   = CNT_W'(T_WNEG);
  localparam logic [CNT_W-1:0] TPerMin = CNT_W'(T_PER_MIN);
  localparam logic [CNT_W-1:0] TPerMax = CNT_W'(T_PER_MAX);

  logic              stb_q;
  logic [WIDTH-1:0]  d_prev_q;
  logic [WIDTH-1:0]  q_q, q_d;
  logic [VIOL_W-1:0] viol_q, viol_d;
  logic [VIOL_W-1:0] status_q, status_d;
  logic [CNT_W-1:0]  vcnt_q, vcnt_d;
  logic [CNT_W-1:0]  hold_q, hold_d;
  phase_e            phase_q, phase_d;

  logic             rise, fall, d_chg, chk_en;
  logic [CNT_W-1:0] age_q, age_now, hi_cnt, lo_cnt, per_cnt, per_meas;

  assign rise   = stb & ~stb_q;
  assign fall   = ~stb & stb_q;
  assign d_chg  = (d != d_prev_q);
  assign chk_en = set_n & clr_n;

  // age_q lags by one cycle; age_now includes the current cycle.
  assign age_now  = d_chg ? '0 : CNT_W'(sat_inc(32'(age_q), 32'(CntMax)));
  // per_cnt is restarted on the rise itself, so the rise-to-rise distance is one more.
  assign per_meas = CNT_W'(sat_inc(32'(per_cnt), 32'(CntMax)));

  fd_sat_timer #(.CNT_W(CNT_W)) u_age (
    .clk       (clk),
    .rst       (rst),
    .restart_i (d_chg),
    .en_i      (1'b1),
    .cnt_o     (age_q)
  );

  fd_sat_timer #(.CNT_W(CNT_W)) u_hi (
    .clk       (clk),
    .rst       (rst),
    .restart_i (~stb),
    .en_i      (stb),
    .cnt_o     (hi_cnt)
  );

  fd_sat_timer #(.CNT_W(CNT_W)) u_lo (
    .clk       (clk),
    .rst       (rst),
    .restart_i (stb),
    .en_i      (~stb),
    .cnt_o     (lo_cnt)
  );

  fd_sat_timer #(.CNT_W(CNT_W)) u_per (
    .clk       (clk),
    .rst       (rst),
    .restart_i (rise),
    .en_i      (1'b1),
    .cnt_o     (per_cnt)
  );

  always_comb begin
    phase_d = phase_q;
    viol_d  = '0;
    unique case (phase_q)
      PhIdle: if (rise) phase_d = PhHigh;
      PhHigh: begin
        if (fall) begin
          phase_d           = PhLow;
          viol_d[VIOL_WPOS] = (hi_cnt < TWpos);
        end
      end
      PhLow: begin
        if (rise) begin
          phase_d           = PhHigh;
          viol_d[VIOL_WNEG] = (lo_cnt < TWneg);
        end
      end
      default: phase_d = PhIdle;
    endcase
    if (rise && (phase_q != PhIdle)) begin
      viol_d[VIOL_PERIOD] = (per_cnt == CntMax) || (per_meas < TPerMin) || (per_meas > TPerMax);
    end
    viol_d[VIOL_SETUP] = rise && (age_now < TSetup);
    viol_d[VIOL_HOLD]  = !rise && (hold_q != '0) && d_chg;
    if (!chk_en) viol_d = '0;
  end

  always_comb begin
    q_d = q_q;
    if (!set_n) begin
      q_d = '1;
    end else if (!clr_n) begin
      q_d = '0;
    end else if (rise) begin
      q_d = d;
    end

    hold_d = rise ? THold : ((hold_q != '0) ? hold_q - CNT_W'(1) : '0);

    status_d = (clr_status ? '0 : status_q) | viol_d;

    vcnt_d = vcnt_q;
    if (clr_status) begin
      vcnt_d = {{(CNT_W-1){1'b0}}, |viol_d};
    end else if (|viol_d) begin
      vcnt_d = CNT_W'(sat_inc(32'(vcnt_q), 32'(CntMax)));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stb_q    <= 1'b0;
      d_prev_q <= '0;
      q_q      <= '0;
      viol_q   <= '0;
      status_q <= '0;
      vcnt_q   <= '0;
      hold_q   <= '0;
      phase_q  <= PhIdle;
    end else begin
      stb_q    <= stb;
      d_prev_q <= d;
      q_q      <= q_d;
      viol_q   <= viol_d;
      status_q <= status_d;
      vcnt_q   <= vcnt_d;
      hold_q   <= hold_d;
      phase_q  <= phase_d;
    end
  end

  assign q        = q_q;
  assign viol     = viol_q;
  assign status   = status_q;
  assign viol_cnt = vcnt_q;

endmodule
